sll_seq: RTL
============

Name: sll_seq

Overview:
- Sequential shift-logical-left unit: the left-shift counterpart of the combinational right shifter in the HW2 catalog.
- Loads an n-bit operand and a shift amount, then shifts left one bit per enabled clock until done.
- Zero-fill on the right. Reports the last bit shifted out.
- Start/busy/done handshake; intended as a multi-cycle datapath element for the catalog's ALU/datapath exercises.

Parameters:
- n, 8, operand/result width in bits (n >= 2).
- amt_w, $clog2(n), width of the shift-amount input (derived; do not override).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  global enable; low stalls all state and register updates except reset.
- start  input  1  request to begin a shift; sampled only in IDLE with en=1.
- in  input  n  operand; captured on accepted start.
- amt  input  amt_w  shift amount, 0..n-1; captured on accepted start.
- busy  output  1  high while in SHIFT state.
- done  output  1  one-cycle pulse; result valid.
- out  output  n  shift register contents; final result when done=1.
- carry  output  1  last bit shifted out of the MSB; 0 if amt=0.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, out=0, carry=0, count=0, busy=0, done=0. Reset asserted mid-shift aborts immediately; no done is produced.
- FSM states: IDLE, SHIFT, DONE. busy=(state==SHIFT), done=(state==DONE). Both are decoded from registered state, with no combinational path from inputs.
- en=0: no state, count, out, or carry change. A DONE state is held, so done stays high until en returns and the next edge occurs.
- IDLE, edge with en=1 and start=1:
  - out<=in, carry<=0, count<=amt.
  - Next state is SHIFT if amt!=0, else DONE.
- IDLE, edge with start=0: hold; out and carry keep the previous result.
- SHIFT, each edge with en=1:
  - out<={out[n-2:0],1'b0}, carry<=out[n-1], count<=count-1.
  - If count==1, next state is DONE; otherwise stay in SHIFT.
- DONE, edge with en=1: next state IDLE. start in this cycle is ignored; start is accepted only from IDLE.
- start while busy or in DONE: ignored. in and amt changes during SHIFT have no effect.
- Latency, with en held high and start accepted at edge 0: done is high in the cycle after edge amt. amt=0 gives done right after the load edge. Throughput is one operation per amt+2 cycles.
- Result: out = (in << amt) truncated to n bits; carry = in[n-amt] for amt>=1.
- out is visible during SHIFT (intermediate values). Consumers qualify it with done.
- Counter width is amt_w and never underflows: SHIFT is only entered with count>=1.

Decomposition:
- Package sll_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} sll_state_t.
  - Helper function for amt_w.
- No sub-module: the single-bit shift step is one line. The whole block is one always_ff plus next-state logic.

Test Plan:
- Reset then idle: rst_n=0 mid-cycle -> out=0, carry=0, busy=0, done=0 immediately (asynchronous). Release, start=0 for 5 cycles -> outputs unchanged.
- Basic shift: in=8'b1011_0001, amt=3, start pulse -> busy high 3 cycles, intermediate out=0110_0010, 1100_0100; then done pulse with out=8'b1000_1000, carry=1.
- Zero amount: in=8'hA5, amt=0 -> done in the cycle after the accept edge, busy never high, out=8'hA5, carry=0.
- Max amount and stall: in=8'hFF, amt=7 with en=0 for 2 cycles mid-shift -> total 9 cycles to done, out=8'h80, carry=1, no change while en=0.
- Ignored start and mid-op reset: start pulsed with new in/amt during SHIFT -> result reflects the original operands. Repeat with rst_n pulsed low mid-SHIFT -> immediate IDLE, out=0, no done.
- Exhaustive: all in 0..255 x amt 0..7 with en=1 -> out=(in<<amt)&8'hFF and carry=in[8-amt] (0 for amt=0) at every done; done exactly once per start.

Source files
------------

// File: rtl/sll_pkg.sv
// Shared types and helpers for the sequential shift-left unit.
package sll_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sll_state_t;

    // Width of the shift-amount field; kept at least one bit wide.
    function automatic int amt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/sll_seq.sv
// Sequential logical left shifter: loads an operand and shift amount, then shifts
// one bit per enabled clock, reporting the last bit shifted out of the MSB.
module sll_seq
    import sll_pkg::*;
#(
    parameter int n     = 8,
    parameter int amt_w = amt_width(n)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic [n-1:0]     in,
    input  logic [amt_w-1:0] amt,
    output logic             busy,
    output logic             done,
    output logic [n-1:0]     out,
    output logic             carry
);

    sll_state_t       state_q, state_d;
    logic [n-1:0]     out_q, out_d;
    logic             carry_q, carry_d;
    logic [amt_w-1:0] count_q, count_d;

    // NOTE: every register sits in one async-reset process updated with <=, so all
    // flops sample the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            carry_q <= carry_d;
            count_q <= count_d;
        end
    end

    // NOTE: defaults come first so every path assigns every signal and no latch forms;
    // holding all state when en is low falls out of those defaults.
    always_comb begin
        state_d = state_q;
        if (en) begin
            case (state_q)
                IDLE:    if (start) state_d = (amt != '0) ? SHIFT : DONE;
                SHIFT:   if (count_q == amt_w'(1)) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        out_d   = out_q;
        carry_d = carry_q;
        count_d = count_q;
        if (en) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        out_d   = in;
                        carry_d = 1'b0;
                        count_d = amt;
                    end
                end
                SHIFT: begin
                    out_d   = {out_q[n-2:0], 1'b0};
                    carry_d = out_q[n-1];
                    count_d = count_q - amt_w'(1);
                end
                default: ;
            endcase
        end
    end

    // Status flags are decoded from registered state only.
    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
    end

    assign out   = out_q;
    assign carry = carry_q;

endmodule
